tsbus_slot_reader: RTL and testbench

//  Read-side master for the shared tri-state timing bus. Scans NSLOT Dflipflop-based source

---
 rtl/tsbus_pkg.sv | 12 +
 rtl/tsbus_slot_reader_if.sv | 22 ++
 rtl/tsbus_settle_timer.sv | 16 +
 rtl/tsbus_slot_reader.sv | 138 +++++++++++++
 tb/tb_tsbus_slot_reader.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/tsbus_pkg.sv
// tsbus_pkg: constants and reader FSM encodings shared by the bus drivers, this reader and the signal controller.
package tsbus_pkg;
    localparam int TSBUS_W = 8;
    localparam int TSBUS_NSLOT = 4;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENABLE  = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_GAP     = 3'd3,
        ST_PRESENT = 3'd4
    } rdr_state_e;
endpackage

// File: rtl/tsbus_slot_reader_if.sv
// tsbus_slot_reader_if: scan control, bus enables/data and snapshot handshake of the slot reader.
interface tsbus_slot_reader_if #(
    parameter int NSLOT = tsbus_pkg::TSBUS_NSLOT,
    parameter int W = tsbus_pkg::TSBUS_W
);
    logic start;
    logic busy;
    logic [NSLOT-1:0] rd_en;
    logic [W-1:0] bus_in;
    logic [NSLOT*W-1:0] slot_data;
    logic out_valid;
    logic out_ready;
    logic [NSLOT-1:0] err_unstable;
    modport master (
        input start, bus_in, out_ready,
        output busy, rd_en, slot_data, out_valid, err_unstable
    );
    modport slave (
        output start, bus_in, out_ready,
        input busy, rd_en, slot_data, out_valid, err_unstable
    );
endinterface

// File: rtl/tsbus_settle_timer.sv
// tsbus_settle_timer: loadable down-counter; done is high while the count rests at zero.
module tsbus_settle_timer #(
    parameter int CW = 4
) (
    input logic Clk,
    input logic Clear,
    input logic load,
    input logic dec,
    input logic [CW-1:0] load_val,
    output logic done
);
    logic [CW-1:0] count_q, count_d;
    always_comb count_d = load ? load_val : (dec && count_q != '0) ? count_q - CW'(1) : count_q;
    always_ff @(posedge Clk) count_q <= Clear ? '0 : count_d;
    assign done = count_q == '0;
endmodule

// File: rtl/tsbus_slot_reader.sv
// tsbus_slot_reader: scans NSLOT tri-state bus sources one at a time and presents an atomic snapshot.
// RDR_STABLE_FILTER_EN: resample each slot until two consecutive reads agree, flagging slots that never settle.
module tsbus_slot_reader
    import tsbus_pkg::*;
#(
    parameter int NSLOT = TSBUS_NSLOT,
    parameter int W = TSBUS_W,
    parameter int SETTLE = 1,
    parameter int RETRY_MAX = 3
) (
    input logic Clk,
    input logic Clear,
    tsbus_slot_reader_if.master bus
);
    localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int CW = $clog2(SETTLE + RETRY_MAX + 1) + 1;
    rdr_state_e state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [NSLOT-1:0] rd_en_q, rd_en_d;
    logic busy_q, busy_d;
    logic out_valid_q, out_valid_d;
    logic [NSLOT-1:0][W-1:0] shadow_q, shadow_d;
    logic [NSLOT-1:0][W-1:0] slot_data_q, slot_data_d;
    logic t_load, t_dec, t_done;
    logic [CW-1:0] t_val;
`ifdef RDR_STABLE_FILTER_EN
    logic [NSLOT-1:0] err_q, err_d;
    logic [W-1:0] prev_q, prev_d;
    logic first_q, first_d;
`endif

    tsbus_settle_timer #(.CW(CW)) u_timer (
        .Clk(Clk),
        .Clear(Clear),
        .load(t_load),
        .dec(t_dec),
        .load_val(t_val),
        .done(t_done)
    );

    always_comb begin
        state_d = state_q;
        slot_d = slot_q;
        shadow_d = shadow_q;
        slot_data_d = slot_data_q;
        t_load = 1'b0;
        t_dec = 1'b0;
        t_val = CW'(SETTLE - 1);
`ifdef RDR_STABLE_FILTER_EN
        err_d = err_q;
        prev_d = prev_q;
        first_d = first_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    slot_d = '0;
                    t_load = 1'b1;
                    state_d = ST_ENABLE;
`ifdef RDR_STABLE_FILTER_EN
                    err_d = '0;
`endif
                end
            end
            ST_ENABLE: begin
                t_dec = 1'b1;
                if (t_done) begin
                    state_d = ST_SAMPLE;
`ifdef RDR_STABLE_FILTER_EN
                    first_d = 1'b1;
`endif
                end
            end
            ST_SAMPLE: begin
`ifdef RDR_STABLE_FILTER_EN
                // first cycle only captures; later cycles compare against the previous read
                if (first_q) begin
                    prev_d = bus.bus_in;
                    first_d = 1'b0;
                    t_load = 1'b1;
                    t_val = CW'(RETRY_MAX);
                end else if (bus.bus_in == prev_q || t_done) begin
                    shadow_d[slot_q] = bus.bus_in;
                    err_d[slot_q] = bus.bus_in != prev_q;
                    state_d = ST_GAP;
                end else begin
                    prev_d = bus.bus_in;
                    t_dec = 1'b1;
                end
`else
                shadow_d[slot_q] = bus.bus_in;
                state_d = ST_GAP;
`endif
            end
            ST_GAP: begin
                if (slot_q == SW'(NSLOT - 1)) begin
                    slot_data_d = shadow_q;
                    state_d = ST_PRESENT;
                end else begin
                    slot_d = slot_q + SW'(1);
                    t_load = 1'b1;
                    state_d = ST_ENABLE;
                end
            end
            ST_PRESENT: state_d = bus.out_ready ? ST_IDLE : ST_PRESENT;
            default: state_d = ST_IDLE;
        endcase
        // outputs are registered from the next state so they line up with it
        rd_en_d = (state_d == ST_ENABLE || state_d == ST_SAMPLE) ? {{(NSLOT-1){1'b0}}, 1'b1} << slot_d : '0;
        busy_d = state_d != ST_IDLE;
        out_valid_d = state_d == ST_PRESENT;
    end

    always_ff @(posedge Clk) begin
        state_q <= Clear ? ST_IDLE : state_d;
        slot_q <= Clear ? '0 : slot_d;
        rd_en_q <= Clear ? '0 : rd_en_d;
        busy_q <= Clear ? 1'b0 : busy_d;
        out_valid_q <= Clear ? 1'b0 : out_valid_d;
        shadow_q <= Clear ? '0 : shadow_d;
        slot_data_q <= Clear ? '0 : slot_data_d;
`ifdef RDR_STABLE_FILTER_EN
        err_q <= Clear ? '0 : err_d;
        prev_q <= Clear ? '0 : prev_d;
        first_q <= Clear ? 1'b0 : first_d;
`endif
    end

    assign bus.rd_en = rd_en_q;
    assign bus.busy = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.slot_data = slot_data_q;
`ifdef RDR_STABLE_FILTER_EN
    assign bus.err_unstable = err_q;
`else
    assign bus.err_unstable = '0;
`endif
endmodule

// File: tb/tb_tsbus_slot_reader.sv
// tb_tsbus_slot_reader: scoreboard bench for the slot reader with modelled bus sources and a contention monitor.
module tb_tsbus_slot_reader;
    localparam int NSLOT = 4;
    localparam int W = 8;
    localparam int SETTLE = 1;
    localparam int RETRY_MAX = 3;
    localparam int LAT = NSLOT * (SETTLE + 2) + 1;

    logic Clk = 1'b0;
    logic Clear = 1'b1;
    always #5 Clk = ~Clk;

    tsbus_slot_reader_if #(.NSLOT(NSLOT), .W(W)) bus ();
    tsbus_slot_reader #(.NSLOT(NSLOT), .W(W), .SETTLE(SETTLE), .RETRY_MAX(RETRY_MAX)) dut (
        .Clk(Clk),
        .Clear(Clear),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fails = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // bus sources: mode 1 makes slot 1 toggle every cycle, mode 2 glitches it on the first sample
    logic [W-1:0] src [NSLOT];
    int mode = 0;
    logic tog = 1'b0;
    int en_cnt = 0;
    logic [NSLOT-1:0] prev_en = '0;
    always @(posedge Clk) begin
        tog <= ~tog;
        en_cnt <= (bus.rd_en == '0) ? 0 : (bus.rd_en == prev_en) ? en_cnt + 1 : 1;
        prev_en <= bus.rd_en;
    end
    always_comb begin
        bus.bus_in = '0;
        for (int i = 0; i < NSLOT; i++) if (bus.rd_en[i]) bus.bus_in = src[i];
        if (bus.rd_en[1] && mode == 1) bus.bus_in = tog ? 8'hA5 : 8'h5A;
        if (bus.rd_en[1] && mode == 2) bus.bus_in = (en_cnt <= 1) ? 8'hFF : 8'h5A;
    end

    int cont_err = 0;
    logic [NSLOT-1:0] last_en = '0;
    always @(negedge Clk) begin
        if (!Clear) begin
            if ($countones(bus.rd_en) > 1) cont_err++;
            if (last_en != '0 && bus.rd_en != '0 && bus.rd_en != last_en) cont_err++;
        end
        last_en = bus.rd_en;
    end

    logic [NSLOT*W-1:0] exp_q[$];
    logic [NSLOT*W-1:0] mask_q[$];
    logic [NSLOT-1:0] experr_q[$];
    int snaps = 0;
    int exp_snaps = 0;
    always @(negedge Clk) begin
        if (!Clear && bus.out_valid && bus.out_ready) begin
            snaps++;
            if (exp_q.size() == 0) check("extra_snapshot", 1, 0);
            else begin
                logic [NSLOT*W-1:0] e, m;
                logic [NSLOT-1:0] er;
                e = exp_q.pop_front();
                m = mask_q.pop_front();
                er = experr_q.pop_front();
                check("snap_data", bus.slot_data & m, e & m);
                check("snap_err", bus.err_unstable, er);
            end
        end
    end

    function automatic logic [NSLOT*W-1:0] pack_src();
        logic [NSLOT*W-1:0] r;
        for (int i = 0; i < NSLOT; i++) r[i*W +: W] = src[i];
        return r;
    endfunction

    task automatic run_scan(input logic [NSLOT*W-1:0] exp, input logic [NSLOT*W-1:0] mask,
                            input logic [NSLOT-1:0] experr, input int hold, input bit poke);
        int n;
        logic [NSLOT-1:0] seq[$];
        exp_q.push_back(exp);
        mask_q.push_back(mask);
        experr_q.push_back(experr);
        exp_snaps++;
        bus.start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            bus.start = poke && n == 5;
            if (bus.rd_en != '0 && (seq.size() == 0 || seq[seq.size()-1] != bus.rd_en)) seq.push_back(bus.rd_en);
        end while (!bus.out_valid && n < 400);
        check("valid_seen", bus.out_valid, 1);
`ifndef RDR_STABLE_FILTER_EN
        check("latency", n, LAT);
`endif
        check("scan_len", seq.size(), NSLOT);
        for (int i = 0; i < NSLOT && i < seq.size(); i++) check("scan_order", seq[i], 1 << i);
        for (int h = 0; h < hold; h++) begin
            bus.start = poke && h < 2;
            tick();
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.slot_data & mask, exp & mask);
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("ret_valid", bus.out_valid, 0);
        check("ret_busy", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int bs;
        int n;
        logic [NSLOT*W-1:0] m;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        src[0] = 8'h11;
        src[1] = 8'h22;
        src[2] = 8'h33;
        src[3] = 8'h44;
        repeat (2) tick();
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.slot_data, 0);
        check("rst_err", bus.err_unstable, 0);
        Clear = 1'b0;
        tick();

        run_scan(32'h44332211, '1, '0, 5, 1'b0);
        check("after_scan_data", bus.slot_data, 32'h44332211);

        bus.start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            bus.start = 1'b0;
        end while (bus.rd_en != 4'b0100 && n < 100);
        check("reach_slot2", bus.rd_en, 4'b0100);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("clr_rd_en", bus.rd_en, 0);
        check("clr_busy", bus.busy, 0);
        check("clr_valid", bus.out_valid, 0);
        check("clr_data", bus.slot_data, 0);
        repeat (3) tick();
        check("clr_idle", bus.busy, 0);

        src[0] = 8'hAA;
        src[1] = 8'hBB;
        src[2] = 8'hCC;
        src[3] = 8'hDD;
        run_scan(pack_src(), '1, '0, 4, 1'b1);
        bs = 0;
        repeat (10) begin
            tick();
            bs |= int'(bus.busy);
        end
        check("no_rescan", bs, 0);

        repeat (3) begin
            for (int i = 0; i < NSLOT; i++) src[i] = W'($urandom_range(0, 255));
            run_scan(pack_src(), '1, '0, 0, 1'b0);
        end

`ifdef RDR_STABLE_FILTER_EN
        src[0] = 8'h01;
        src[1] = 8'h5A;
        src[2] = 8'h03;
        src[3] = 8'h04;
        m = '1;
        m[W +: W] = '0;
        mode = 1;
        run_scan(pack_src(), m, 4'b0010, 0, 1'b0);
        mode = 2;
        run_scan(pack_src(), '1, 4'b0000, 0, 1'b0);
        mode = 0;
`else
        m = '1;
`endif
        check("snap_mask_used", m[7:0], 8'hFF);

        tick();
        check("contention", cont_err, 0);
        check("snap_count", snaps, exp_snaps);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
